// File: rtl/mest_pro_mem_pkg.sv
// rtl/mest_pro_mem_pkg.sv - shared widths, read-stage type and parity helper for the MESTPro memory
package mest_pro_mem_pkg;

  localparam int OP_CODE_SIZE     = 4;
  localparam int INSTRUCTION_SIZE = OP_CODE_SIZE + 8 + 8 + 8;
  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_PARITY_W     = 64;

  typedef struct packed {
    logic                        valid;
    logic                        fault;
    logic [INSTRUCTION_SIZE-1:0] data;
  } rd_stage_t;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic parity_f(input logic [MAX_PARITY_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mest_pro_mem_pipe.sv
// rtl/mest_pro_mem_pipe.sv - flushable delay line of {valid, fault, data} read stages
module mest_pro_mem_pipe #(
  parameter int DATA_WIDTH = 28,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_fault,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic                  o_fault,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_next_valid,
  output logic                  o_next_fault
);

  typedef struct packed {
    logic                  valid;
    logic                  fault;
    logic [DATA_WIDTH-1:0] data;
  } stage_t;

  stage_t stg  [STAGES];
  stage_t feed [STAGES];

  always_comb begin
    feed[0] = '{valid: i_valid, fault: i_fault, data: i_data};
    for (int i = 1; i < STAGES; i++) feed[i] = stg[i-1];
  end

  // Data only advances behind a valid entry, so the output word holds between strobes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (i_reset) begin
        stg[i] <= '0;
      end else begin
        stg[i].valid <= feed[i].valid;
        stg[i].fault <= feed[i].fault;
        if (feed[i].valid) stg[i].data <= feed[i].data;
      end
    end
  end

  assign o_valid      = stg[STAGES-1].valid;
  assign o_fault      = stg[STAGES-1].fault;
  assign o_data       = stg[STAGES-1].data;
  assign o_next_valid = feed[STAGES-1].valid;
  assign o_next_fault = feed[STAGES-1].fault;

endmodule

// File: rtl/mest_pro_mem_gen.sv
// rtl/mest_pro_mem_gen.sv - parametrised MESTPro program/data memory with range check and error count
// Optional parity storage and check enabled by MEST_MEM_PARITY_EN.
module mest_pro_mem_gen
  import mest_pro_mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = INSTRUCTION_SIZE,
  parameter int    DEPTH        = 65536,
  parameter int    READ_LATENCY = 1,
  parameter int    ERR_CNT_W    = 8,
  parameter string INIT_FILE    = ""
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic                       i_cs,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic                       o_rvalid,
  output logic                       o_error,
  output logic [ERR_CNT_W-1:0]       o_err_count
);

`ifdef MEST_MEM_PARITY_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
    $error("READ_LATENCY must be within 1..MAX_READ_LATENCY");
  end

  logic [MEM_W-1:0] mem [DEPTH];

  logic                  accept, range_fault, rd_fault, wr_fault_q;
  logic                  pipe_valid, pipe_fault, next_valid, next_fault;
  logic [MEM_W-1:0]      rd_word;
  logic [DATA_WIDTH-1:0] pipe_data;
  logic [1:0]            n_err;
  logic [ERR_CNT_W:0]    cnt_sum;

  assign accept      = i_cs & ~i_reset;
  assign range_fault = 32'(i_addr) >= 32'(DEPTH);
  assign rd_word     = range_fault ? '0 : mem[i_addr];

`ifdef MEST_MEM_PARITY_EN
  assign rd_fault = range_fault |
                    (parity_f(MAX_PARITY_W'(rd_word[DATA_WIDTH-1:0])) != rd_word[DATA_WIDTH]);
`else
  assign rd_fault = range_fault;
`endif

  always_ff @(posedge clk) begin
    if (accept & i_we & ~range_fault) begin
`ifdef MEST_MEM_PARITY_EN
      mem[i_addr] <= {parity_f(MAX_PARITY_W'(i_wdata)), i_wdata};
`else
      mem[i_addr] <= i_wdata;
`endif
    end
  end

  mest_pro_mem_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (READ_LATENCY)
  ) u_pipe (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_valid      (accept & ~i_we),
    .i_fault      (rd_fault),
    .i_data       (rd_word[DATA_WIDTH-1:0]),
    .o_valid      (pipe_valid),
    .o_fault      (pipe_fault),
    .o_data       (pipe_data),
    .o_next_valid (next_valid),
    .o_next_fault (next_fault)
  );

  // A read fault leaving the pipe and a write fault can land on the same edge; both count.
  assign n_err   = {1'b0, next_valid & next_fault} + {1'b0, accept & i_we & range_fault};
  assign cnt_sum = {1'b0, o_err_count} + (ERR_CNT_W+1)'(n_err);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_fault_q  <= 1'b0;
      o_err_count <= '0;
    end else begin
      wr_fault_q  <= accept & i_we & range_fault;
      o_err_count <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
    end
  end

  assign o_rdata  = pipe_data;
  assign o_rvalid = pipe_valid;
  assign o_error  = wr_fault_q | (pipe_valid & pipe_fault);

endmodule
